// File: rtl/imem_line_server_if.sv
// rtl/imem_line_server_if.sv - refill read handshake and word load port bundle
interface imem_line_server_if;
    logic [31:0]  mem_bus_address;
    logic         mem_read_start;
    logic [127:0] mem_bus_data;
    logic         mem_read_rdy;
    logic         load_we;
    logic [31:0]  load_addr;
    logic [31:0]  load_data;

    modport master (
        output mem_bus_address,
        output mem_read_start,
        input  mem_bus_data,
        input  mem_read_rdy,
        output load_we,
        output load_addr,
        output load_data
    );

    modport slave (
        input  mem_bus_address,
        input  mem_read_start,
        output mem_bus_data,
        output mem_read_rdy,
        input  load_we,
        input  load_addr,
        input  load_data
    );
endinterface

// File: rtl/imem_line_server.sv
// rtl/imem_line_server.sv - instruction line memory with fixed-latency refill reads (option: IMEM_OOR_ERR_EN)
module imem_line_server #(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_line_server_if.slave    bus,
    output logic                 busy
`ifdef IMEM_OOR_ERR_EN
    ,
    output logic                 mem_err
`endif
);
    localparam int         IDX_W    = $clog2(DEPTH_LINES);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         cnt;
    logic [127:0]       data_q;
    logic               rdy_q;

    // Line storage; deliberately has no reset so preloaded images survive reset.
    logic [127:0]       lines [DEPTH_LINES];

    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   ld_idx;
    logic [1:0]         ld_sel;
    logic               ld_ok;
    logic               unused_addr_bits;

    assign rd_idx = bus.mem_bus_address[4 +: IDX_W];
    assign ld_idx = bus.load_addr[4 +: IDX_W];
    // Word 0 sits in the top 32 bits of the line, so flip the word number into a slice index.
    assign ld_sel = 2'd3 - bus.load_addr[3:2];

    // Bits outside the line index only matter for the range check, if at all.
    assign unused_addr_bits = ^{bus.mem_bus_address, bus.load_addr};

`ifdef IMEM_OOR_ERR_EN
    logic rd_oor;
    logic oor;
    assign rd_oor = (bus.mem_bus_address[31:4] >= 28'(DEPTH_LINES));
    assign ld_ok  = (bus.load_addr[31:4] < 28'(DEPTH_LINES));
`else
    assign ld_ok  = 1'b1;
`endif

    assign bus.mem_bus_data = data_q;
    assign bus.mem_read_rdy = rdy_q;

    // Word load port: one 32-bit word per edge, any state; a capture on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (bus.load_we && ld_ok) begin
            lines[ld_idx][{ld_sel, 5'd0} +: 32] <= bus.load_data;
        end
    end

    // Request FSM: latch index, count down the latency, then hold the line until start drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= 8'd0;
            data_q <= '0;
            rdy_q  <= 1'b0;
            busy   <= 1'b0;
`ifdef IMEM_OOR_ERR_EN
            oor     <= 1'b0;
            mem_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_read_start) begin
                        idx   <= rd_idx;
                        cnt   <= CNT_INIT;
                        state <= COUNT;
                        busy  <= 1'b1;
`ifdef IMEM_OOR_ERR_EN
                        oor   <= rd_oor;
`endif
                    end
                end
                COUNT: begin
                    if (!bus.mem_read_start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
`ifdef IMEM_OOR_ERR_EN
                        data_q  <= oor ? '0 : lines[idx];
                        mem_err <= oor;
`else
                        data_q  <= lines[idx];
`endif
                        rdy_q <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (!bus.mem_read_start) begin
                        rdy_q <= 1'b0;
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef IMEM_OOR_ERR_EN
                        mem_err <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
